// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with bypass, pending-write scoreboard and post-reset clear
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD*$clog2(NREG)-1:0] rd_addr_i,
    output logic [NRD*XLEN-1:0]      rd_data_o,
    output logic [NRD-1:0]           rd_busy_o,
    input  logic [NWR-1:0]           we_i,
    input  logic [NWR*$clog2(NREG)-1:0] wa_i,
    input  logic [NWR*XLEN-1:0]      wd_i,
    input  logic                     sb_set_i,
    input  logic [$clog2(NREG)-1:0]  sb_addr_i,
    output logic                     ready_o
);
    localparam int AW = $clog2(NREG);

    typedef enum logic {
        S_CLR = 1'b0,
        S_RUN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       clr_idx_q, clr_idx_d;
    logic [NREG-1:0]     pending_q, pending_d;
    logic [XLEN-1:0]     mem_q [NREG];
    logic [NWR-1:0]      wr_commit;

    always_comb begin
        wr_commit = '0;
        for (int j = 0; j < NWR; j++) begin
            wr_commit[j] = (state_q == S_RUN) && we_i[j] && (wa_i[j*AW +: AW] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_CLR;
            clr_idx_q <= AW'(1);
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        pending_d = pending_q;
        case (state_q)
            S_CLR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NREG - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_commit[j]) begin
                        pending_d[wa_i[j*AW +: AW]] = 1'b0;
                    end
                end
                // a producer issued this cycle outranks a retiring older write
                if (sb_set_i) begin
                    pending_d[sb_addr_i] = 1'b1;
                end
            end
            default: state_d = S_CLR;
        endcase
        pending_d[0] = 1'b0;
    end

    // later ports overwrite earlier ones, so the highest index wins
    always_ff @(posedge clk) begin
        if (state_q == S_CLR) begin
            mem_q[clr_idx_q] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_commit[j]) begin
                    mem_q[wa_i[j*AW +: AW]] <= wd_i[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdata;
        logic            rbusy;
        ra        = '0;
        rdata     = '0;
        rbusy     = 1'b0;
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int k = 0; k < NRD; k++) begin
            ra    = rd_addr_i[k*AW +: AW];
            rdata = mem_q[ra];
            rbusy = pending_q[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_commit[j] && (wa_i[j*AW +: AW] == ra)) begin
                        rdata = wd_i[j*XLEN +: XLEN];
                        rbusy = 1'b0;
                    end
                end
            end
            if ((ra == '0) || (state_q != S_RUN)) begin
                rdata = '0;
                rbusy = 1'b0;
            end
            rd_data_o[k*XLEN +: XLEN] = rdata;
            rd_busy_o[k]              = rbusy;
        end
    end

    assign ready_o = (state_q == S_RUN);

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed bench for regfile_mp (bypassing two-writer and non-bypass instances)
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;

    logic [9:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic [1:0]  rd_busy_a;
    logic [1:0]  we_a;
    logic [9:0]  wa_a;
    logic [63:0] wd_a;
    logic        sb_set_a;
    logic [4:0]  sb_addr_a;
    logic        ready_a;

    logic [9:0]  rd_addr_b;
    logic [63:0] rd_data_b;
    logic [1:0]  rd_busy_b;
    logic [0:0]  we_b;
    logic [4:0]  wa_b;
    logic [31:0] wd_b;
    logic        sb_set_b;
    logic [4:0]  sb_addr_b;
    logic        ready_b;

    int total = 0;
    int bad   = 0;

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .rd_addr_i(rd_addr_a), .rd_data_o(rd_data_a), .rd_busy_o(rd_busy_a),
        .we_i(we_a), .wa_i(wa_a), .wd_i(wd_a),
        .sb_set_i(sb_set_a), .sb_addr_i(sb_addr_a), .ready_o(ready_a)
    );

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(1), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .rd_addr_i(rd_addr_b), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
        .we_i(we_b), .wa_i(wa_b), .wd_i(wd_b),
        .sb_set_i(sb_set_b), .sb_addr_i(sb_addr_b), .ready_o(ready_b)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        rd_addr_a = '0; we_a = '0; wa_a = '0; wd_a = '0; sb_set_a = 1'b0; sb_addr_a = '0;
        rd_addr_b = '0; we_b = '0; wa_b = '0; wd_b = '0; sb_set_b = 1'b0; sb_addr_b = '0;
    endtask

    task automatic wait_ready(input string name);
        int cyc;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ready_a) break;
        end
        idle_inputs();
        total++;
        if (cyc != 31) begin
            bad++;
            $display("FAIL %s_latency got=%0d exp=31", name, cyc);
        end
        total++;
        if (ready_b !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready_b got=%b exp=1", name, ready_b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        rd_addr_a = {5'd7, 5'd5};
        #1;
        total++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%b%b exp=00", ready_a, ready_b);
        end
        total++;
        if (rd_data_a !== 64'h0 || rd_busy_a !== 2'b00) begin
            bad++;
            $display("FAIL reset_read got=%h/%b exp=0/00", rd_data_a, rd_busy_a);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ready("reset");
    endtask

    task automatic test_clear_reads(input string name);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = {5'(2*i+1), 5'(2*i)};
            rd_addr_b = {5'(2*i+1), 5'(2*i)};
            #1;
            total++;
            if (rd_data_a !== 64'h0 || rd_busy_a !== 2'b00 || rd_data_b !== 64'h0 || rd_busy_b !== 2'b00) begin
                bad++;
                $display("FAIL %s_zero_%0d got=%h/%b %h/%b exp=0/00", name, i, rd_data_a, rd_busy_a, rd_data_b, rd_busy_b);
            end
        end
        idle_inputs();
    endtask

    task automatic test_write();
        @(negedge clk);
        we_a = 2'b01; wa_a = {5'd0, 5'd5}; wd_a = {32'h0, 32'hDEADBEEF};
        rd_addr_a = {5'd0, 5'd6};
        @(negedge clk);
        idle_inputs();
        rd_addr_a = {5'd0, 5'd5};
        #1;
        total++;
        if (rd_data_a[31:0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_addr5 got=%h exp=deadbeef", rd_data_a[31:0]);
        end
        @(negedge clk);
        we_a = 2'b01; wa_a = '0; wd_a = {32'h0, 32'hDEADBEEF};
        rd_addr_a = '0;
        #1;
        total++;
        if (rd_data_a[31:0] !== 32'h0) begin
            bad++;
            $display("FAIL write_x0_same got=%h exp=0", rd_data_a[31:0]);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        total++;
        if (rd_data_a !== 64'h0) begin
            bad++;
            $display("FAIL write_x0_after got=%h exp=0", rd_data_a);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we_a = 2'b01; wa_a = {5'd0, 5'd7}; wd_a = {32'h0, 32'h12345678};
        rd_addr_a = {5'd7, 5'd0};
        we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h12345678;
        rd_addr_b = {5'd7, 5'd0};
        #1;
        total++;
        if (rd_data_a[63:32] !== 32'h12345678) begin
            bad++;
            $display("FAIL bypass_same_cycle got=%h exp=12345678", rd_data_a[63:32]);
        end
        total++;
        if (rd_data_b[63:32] !== 32'h0) begin
            bad++;
            $display("FAIL nobypass_old got=%h exp=0", rd_data_b[63:32]);
        end
        @(negedge clk);
        idle_inputs();
        rd_addr_a = {5'd7, 5'd0};
        rd_addr_b = {5'd7, 5'd0};
        #1;
        total++;
        if (rd_data_b[63:32] !== 32'h12345678 || rd_data_a[63:32] !== 32'h12345678) begin
            bad++;
            $display("FAIL write_next_cycle got=%h/%h exp=12345678", rd_data_a[63:32], rd_data_b[63:32]);
        end
    endtask

    task automatic test_conflict();
        @(negedge clk);
        we_a = 2'b11; wa_a = {5'd3, 5'd3}; wd_a = {32'h5555FFFF, 32'hAAAA0000};
        rd_addr_a = {5'd0, 5'd3};
        #1;
        total++;
        if (rd_data_a[31:0] !== 32'h5555FFFF) begin
            bad++;
            $display("FAIL conflict_bypass got=%h exp=5555ffff", rd_data_a[31:0]);
        end
        @(negedge clk);
        idle_inputs();
        rd_addr_a = {5'd3, 5'd3};
        #1;
        total++;
        if (rd_data_a !== 64'h5555FFFF_5555FFFF) begin
            bad++;
            $display("FAIL conflict_commit got=%h exp=5555ffff5555ffff", rd_data_a);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        sb_set_a = 1'b1; sb_addr_a = 5'd9; rd_addr_a = {5'd0, 5'd9};
        sb_set_b = 1'b1; sb_addr_b = 5'd9; rd_addr_b = {5'd0, 5'd9};
        #1;
        total++;
        if (rd_busy_a[0] !== 1'b0) begin
            bad++;
            $display("FAIL sb_set_same_cycle got=%b exp=0", rd_busy_a[0]);
        end
        @(negedge clk);
        sb_set_a = 1'b0; sb_set_b = 1'b0;
        #1;
        total++;
        if (rd_busy_a !== 2'b01 || rd_busy_b !== 2'b01) begin
            bad++;
            $display("FAIL sb_set_visible got=%b/%b exp=01/01", rd_busy_a, rd_busy_b);
        end
        we_a = 2'b01; wa_a = {5'd0, 5'd9}; wd_a = {32'h0, 32'h00000099};
        we_b = 1'b1; wa_b = 5'd9; wd_b = 32'h00000099;
        #1;
        total++;
        if (rd_busy_a[0] !== 1'b0 || rd_data_a[31:0] !== 32'h99) begin
            bad++;
            $display("FAIL sb_clear_bypass got=%b/%h exp=0/00000099", rd_busy_a[0], rd_data_a[31:0]);
        end
        total++;
        if (rd_busy_b[0] !== 1'b1) begin
            bad++;
            $display("FAIL sb_clear_nobypass_same got=%b exp=1", rd_busy_b[0]);
        end
        @(negedge clk);
        we_b = 1'b0;
        sb_set_a = 1'b1; sb_addr_a = 5'd9;
        #1;
        total++;
        if (rd_busy_a[0] !== 1'b0 || rd_busy_b[0] !== 1'b0) begin
            bad++;
            $display("FAIL sb_cleared got=%b/%b exp=0/0", rd_busy_a[0], rd_busy_b[0]);
        end
        @(negedge clk);
        idle_inputs();
        rd_addr_a = {5'd9, 5'd0};
        #1;
        total++;
        if (rd_busy_a !== 2'b10) begin
            bad++;
            $display("FAIL sb_set_wins got=%b exp=10", rd_busy_a);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        rd_addr_a = {5'd9, 5'd5};
        rst = 1'b1;
        #1;
        total++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
            bad++;
            $display("FAIL midrst_ready got=%b%b exp=00", ready_a, ready_b);
        end
        total++;
        if (rd_data_a !== 64'h0 || rd_busy_a !== 2'b00) begin
            bad++;
            $display("FAIL midrst_read got=%h/%b exp=0/00", rd_data_a, rd_busy_a);
        end
        @(negedge clk);
        rst = 1'b0;
        we_a = 2'b01; wa_a = {5'd0, 5'd2}; wd_a = {32'h0, 32'hFFFFFFFF};
        sb_set_a = 1'b1; sb_addr_a = 5'd4;
        we_b = 1'b1; wa_b = 5'd2; wd_b = 32'hFFFFFFFF;
        sb_set_b = 1'b1; sb_addr_b = 5'd4;
        wait_ready("midrst");
    endtask

    initial begin
        test_reset();
        test_clear_reads("clear");
        test_write();
        test_bypass();
        test_conflict();
        test_scoreboard();
        test_mid_reset();
        test_clear_reads("midrst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the mycpu core, sitting between decode (read ports) and writeback (write ports).
- Adds over the single-issue version: configurable width, depth and port counts, optional write-to-read bypass, and per-register pending-write scoreboard bits for hazard detection.
- Clears every register sequentially after reset and reports readiness to the pipeline.
- x0 is hardwired to zero.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of registers, power of two, ≥4; AW = log2(NREG)
- NRD, 2, number of read ports
- NWR, 1, number of write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rd_addr_i  in  NRD*AW  read addresses; port k in bits [k*AW +: AW]
- rd_data_o  out  NRD*XLEN  read data, combinational
- rd_busy_o  out  NRD  pending-write flag for each read address
- we_i  in  NWR  write enables
- wa_i  in  NWR*AW  write addresses
- wd_i  in  NWR*XLEN  write data
- sb_set_i  in  1  mark register sb_addr_i as pending (issue of a producer)
- sb_addr_i  in  AW  scoreboard set address
- ready_o  out  1  high once the clear sequence is finished

## Operation
- States: CLR and RUN.
  - rst asserted: state is CLR, clear index is 1, all scoreboard bits are 0, and ready_o is 0.
  - In CLR, each cycle writes 0 to entry idx, then increments idx.
  - When idx = NREG-1 is written, the next state is RUN and ready_o goes to 1.
- In CLR:
  - we_i and sb_set_i are ignored.
  - rd_data_o is all-zero and rd_busy_o is 0.
- Write commit in RUN: on a clk edge, for each port j with we_i[j]=1 and wa_i[j]≠0, the entry takes wd_i[j].
  - If several ports write the same address, the highest port index wins.
  - Writes to x0 are discarded.
- Read: rd_data_o[k] is selected in this order:
  - 0 if rd_addr_i[k]=0.
  - Otherwise, if BYPASS=1 and some active port j has wa_i[j]=rd_addr_i[k], the wd_i of the highest such j.
  - Otherwise the stored entry.
- Scoreboard: one pending bit per register; bit 0 is constant 0.
  - On a clk edge in RUN, sb_set_i sets the bit for sb_addr_i.
  - Any committing write clears the bit for its address.
  - Set and commit to the same address in the same cycle: set wins, and the bit stays 1.
- rd_busy_o[k] = pending[rd_addr_i[k]].
  - When BYPASS=1, it is forced to 0 if that address is being written this cycle.
- Assertion of rst mid-clear or mid-run restarts CLR.
  - Register contents are not guaranteed until ready_o returns to 1.

## Timing
- Reset values:
  - ready_o = 0.
  - rd_busy_o = 0.
  - rd_data_o = 0.
  - Scoreboard all 0.
- Clear latency: ready_o rises exactly NREG-1 clk edges after rst deasserts (31 cycles for the defaults).
- Read latency: 0 cycles, combinational from rd_addr_i, the storage array, the scoreboard and (BYPASS) we_i/wa_i/wd_i.
- Write visible to reads:
  - Same cycle when BYPASS=1.
  - Otherwise the cycle after the commit edge.
- Scoreboard set is visible on rd_busy_o the cycle after the sb_set_i edge; a clear follows the same rule unless bypassed.
- There are no stalls or back-pressure. The pipeline must not issue until ready_o=1; operation in CLR is defined by the drop rules above.

## Test plan
- Reset then idle, NREG=32: ready_o rises exactly 31 cycles after rst falls. Every rd_addr then reads 0x00000000, including x0.
- Write test pattern:
  - we_i[0]=1, wa=5, wd=0xDEADBEEF in RUN: the next cycle, a read of addr 5 returns 0xDEADBEEF.
  - The same write to addr 0: a read of x0 returns 0.
- Bypass, BYPASS=1: write addr 7 = 0x12345678 while port 1 reads addr 7, giving 0x12345678 in the same cycle. With BYPASS=0, the old value appears that cycle and the new value the next.
- Port conflict, NWR=2: both ports write addr 3, port 0 with 0xAAAA0000 and port 1 with 0x5555FFFF, giving 0x5555FFFF.
- Scoreboard:
  - sb_set_i with addr 9 gives rd_busy_o=1 on a read of 9.
  - A write to 9 clears it; with BYPASS=1 it reads 0 already in the write cycle.
  - Simultaneous set and write to 9 leaves busy at 1.
- Mid-run reset: pulse rst after registers hold data. ready_o drops immediately, writes during CLR are dropped, and after 31 cycles all reads return 0 with no busy bits set.
